// File: rtl/booth_r4_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller.
//
// Accepts one signed operand pair per start handshake, recodes the multiplier
// two bits per cycle into a {neg, one, two} select code, forms the selected
// partial product (0, +-A, +-2A) and accumulates it, shifted, into a 2N-bit
// signed product over N/2 cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   i_start    request a multiply (sampled only in idle)
//   i_a        signed multiplicand, captured on the accepting edge
//   i_b        signed multiplier, captured on the accepting edge
//   o_busy     high while the multiply is running
//   o_done     single-cycle pulse when o_product has been updated
//   o_product  signed result register, holds the last completed result
//   o_sel      current Booth select code {neg, one, two}, 000 outside run
module booth_r4_seq_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_product,
  output logic [2:0]     o_sel
);

  localparam int unsigned PW = N + 2;
  localparam int unsigned RW = 2 * N;
  localparam int unsigned IW = (N > 4) ? $clog2(N / 2) : 1;
  localparam logic [IW-1:0] LastIter = IW'(N / 2 - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          r_state, w_state_d;
  logic [N-1:0]    r_a, w_a_d;
  logic [N:0]      r_b, w_b_d;        // {b, b_-1}
  logic [RW-1:0]   r_acc, w_acc_d;
  logic [IW-1:0]   r_iter, w_iter_d;
  logic [RW-1:0]   r_product, w_product_d;
  logic            r_done, w_done_d;

  logic [N:0]      w_b_sh;
  logic [2:0]      w_trip;
  logic [2:0]      w_sel;
  logic [PW-1:0]   w_a_ext;
  logic [PW-1:0]   w_mag;
  logic [PW-1:0]   w_pp;
  logic [RW-1:0]   w_pp_ext;
  logic [RW-1:0]   w_pp_sh;
  logic [RW-1:0]   w_acc_sum;

  // Triplet {B[2i+1], B[2i], B[2i-1]} sits at bits [2i+2:2i] of r_b because
  // r_b[0] holds the appended b_-1.
  assign w_b_sh = r_b >> {r_iter, 1'b0};
  assign w_trip = w_b_sh[2:0];

  always_comb begin
    w_sel = 3'b000;
    if (r_state == StRun) begin
      unique case (w_trip)
        3'b000, 3'b111: w_sel = 3'b000;
        3'b001, 3'b010: w_sel = 3'b010;
        3'b011:         w_sel = 3'b001;
        3'b100:         w_sel = 3'b101;
        3'b101, 3'b110: w_sel = 3'b110;
        default:        w_sel = 3'b000;
      endcase
    end
  end

  // Two guard bits keep +-2A exact, including -2 * -2^(N-1).
  assign w_a_ext   = {{2{r_a[N-1]}}, r_a};
  assign w_mag     = w_sel[0] ? (w_a_ext << 1) : (w_sel[1] ? w_a_ext : '0);
  assign w_pp      = w_sel[2] ? (-w_mag) : w_mag;
  assign w_pp_ext  = {{(RW - PW){w_pp[PW-1]}}, w_pp};
  assign w_pp_sh   = w_pp_ext << {r_iter, 1'b0};
  assign w_acc_sum = r_acc + w_pp_sh;

  always_comb begin
    w_state_d   = r_state;
    w_a_d       = r_a;
    w_b_d       = r_b;
    w_acc_d     = r_acc;
    w_iter_d    = r_iter;
    w_product_d = r_product;
    w_done_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_a_d     = i_a;
          w_b_d     = {i_b, 1'b0};
          w_acc_d   = '0;
          w_iter_d  = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        w_acc_d  = w_acc_sum;
        w_iter_d = r_iter + 1'b1;
        if (r_iter == LastIter) begin
          w_product_d = w_acc_sum;
          w_done_d    = 1'b1;
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_iter    <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_a       <= w_a_d;
      r_b       <= w_b_d;
      r_acc     <= w_acc_d;
      r_iter    <= w_iter_d;
      r_product <= w_product_d;
      r_done    <= w_done_d;
    end
  end

  assign o_busy    = (r_state == StRun);
  assign o_done    = r_done;
  assign o_product = r_product;
  assign o_sel     = w_sel;

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Directed testbench for booth_r4_seq_ctrl (N = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_booth_r4_seq_ctrl;

  localparam int unsigned N = 8;

  logic           clk;
  logic           rst_n;
  logic           i_start;
  logic [N-1:0]   i_a;
  logic [N-1:0]   i_b;
  logic           o_busy;
  logic           o_done;
  logic [2*N-1:0] o_product;
  logic [2:0]     o_sel;

  int n_checks = 0;
  int n_errors = 0;

  booth_r4_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_product (o_product),
    .o_sel     (o_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start pulse and wait (bounded) for done. busy_cnt counts the
  // sampled cycles with busy high before the done cycle.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output int busy_cnt, output logic got_done);
    @(negedge clk);
    i_start = 1'b1;
    i_a     = a;
    i_b     = b;
    @(negedge clk);
    i_start  = 1'b0;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_done) begin
        got_done = 1'b1;
        break;
      end
      if (o_busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    #12;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy got %b want 0", o_busy);
    end
    n_checks++;
    if (o_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_done got %b want 0", o_done);
    end
    n_checks++;
    if (o_product !== 16'h0000) begin
      n_errors++; $display("FAIL reset_product got %h want 0000", o_product);
    end
    n_checks++;
    if (o_sel !== 3'b000) begin
      n_errors++; $display("FAIL reset_sel got %b want 000", o_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_idle got busy=%b done=%b want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_basic();
    int   bc;
    logic gd;
    run_op(8'd3, 8'd5, bc, gd);
    n_checks++;
    if (gd !== 1'b1) begin
      n_errors++; $display("FAIL basic_done got %b want 1", gd);
    end
    n_checks++;
    if (bc != 4) begin
      n_errors++; $display("FAIL basic_busy_cycles got %0d want 4", bc);
    end
    n_checks++;
    if (o_product !== 16'h000F || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_product got %h busy=%b want 000f busy=0", o_product, o_busy);
    end
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b0 || o_product !== 16'h000F) begin
      n_errors++;
      $display("FAIL basic_after got done=%b prod=%h want 0 000f", o_done, o_product);
    end
  endtask

  task automatic test_sel_seq();
    logic [2:0] exp_sel [4];
    logic       gd;
    exp_sel[0] = 3'b101;
    exp_sel[1] = 3'b110;
    exp_sel[2] = 3'b001;
    exp_sel[3] = 3'b010;
    @(negedge clk);
    n_checks++;
    if (o_sel !== 3'b000) begin
      n_errors++; $display("FAIL sel_idle got %b want 000", o_sel);
    end
    i_start = 1'b1;
    i_a     = 8'h01;
    i_b     = 8'h5A;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_sel !== exp_sel[k]) begin
        n_errors++; $display("FAIL sel_cycle%0d got %b want %b", k, o_sel, exp_sel[k]);
      end
      @(negedge clk);
    end
    gd = o_done;
    n_checks++;
    if (gd !== 1'b1 || o_product !== 16'h005A || o_sel !== 3'b000) begin
      n_errors++;
      $display("FAIL sel_product got done=%b prod=%h sel=%b want 1 005a 000",
               gd, o_product, o_sel);
    end
  endtask

  task automatic test_corners();
    logic [N-1:0]   ca [4];
    logic [N-1:0]   cb [4];
    logic [2*N-1:0] cp [4];
    int             bc;
    logic           gd;
    ca[0] = 8'h80; cb[0] = 8'h80; cp[0] = 16'h4000;
    ca[1] = 8'h80; cb[1] = 8'h7F; cp[1] = 16'hC080;
    ca[2] = 8'hFF; cb[2] = 8'hFF; cp[2] = 16'h0001;
    ca[3] = 8'h00; cb[3] = 8'h7F; cp[3] = 16'h0000;
    for (int t = 0; t < 4; t++) begin
      run_op(ca[t], cb[t], bc, gd);
      n_checks++;
      if (gd !== 1'b1 || bc != 4 || o_product !== cp[t]) begin
        n_errors++;
        $display("FAIL corner%0d got done=%b busy=%0d prod=%h want 1 4 %h",
                 t, gd, bc, o_product, cp[t]);
      end
      @(negedge clk);
      n_checks++;
      if (o_done !== 1'b0) begin
        n_errors++; $display("FAIL corner%0d_pulse got done=%b want 0", t, o_done);
      end
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    int done_at;
    @(negedge clk);
    i_start = 1'b1;
    i_a     = 8'd7;
    i_b     = 8'd9;
    dones   = 0;
    done_at = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      i_start = (k == 2);
      if (k == 2) begin
        i_a = 8'd2;
        i_b = 8'd2;
      end
      if (o_done) begin
        dones++;
        if (done_at < 0) done_at = k;
        n_checks++;
        if (o_product !== 16'h003F) begin
          n_errors++; $display("FAIL ignore_product got %h want 003f", o_product);
        end
      end
    end
    i_start = 1'b0;
    n_checks++;
    if (dones != 1 || done_at != 4) begin
      n_errors++;
      $display("FAIL ignore_done got count=%0d at=%0d want 1 at 4", dones, done_at);
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_product !== 16'h003F) begin
      n_errors++;
      $display("FAIL ignore_final got busy=%b prod=%h want 0 003f", o_busy, o_product);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]   pa [6];
    logic [N-1:0]   pb [6];
    logic [2*N-1:0] pp [4];
    logic [2*N-1:0] prev;
    int             gap;
    logic           seen;
    pa[0] = 8'd3;   pb[0] = 8'd5;   pp[0] = 16'h000F;
    pa[1] = 8'hFE;  pb[1] = 8'd7;   pp[1] = 16'hFFF2;
    pa[2] = 8'h7F;  pb[2] = 8'h7F;  pp[2] = 16'h3F01;
    pa[3] = 8'h80;  pb[3] = 8'h80;  pp[3] = 16'h4000;
    pa[4] = 8'd1;   pb[4] = 8'd1;
    pa[5] = 8'd2;   pb[5] = 8'd2;
    prev = 16'h003F;
    @(negedge clk);
    i_start = 1'b1;
    i_a     = pa[0];
    i_b     = pb[0];
    @(negedge clk);
    i_a = pa[1];
    i_b = pb[1];
    gap = 1;
    for (int j = 0; j < 4; j++) begin
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (o_done) begin
          seen = 1'b1;
          break;
        end
        n_checks++;
        if (o_product !== prev) begin
          n_errors++; $display("FAIL b2b_stable%0d got %h want %h", j, o_product, prev);
        end
        gap++;
        @(negedge clk);
      end
      n_checks++;
      if (seen !== 1'b1 || o_product !== pp[j]) begin
        n_errors++;
        $display("FAIL b2b_product%0d got done=%b prod=%h want 1 %h", j, seen, o_product, pp[j]);
      end
      if (j > 0) begin
        n_checks++;
        if (gap != 5) begin
          n_errors++; $display("FAIL b2b_gap%0d got %0d want 5", j, gap);
        end
      end
      prev = pp[j];
      gap  = 1;
      @(negedge clk);
      i_a = pa[j + 2];
      i_b = pb[j + 2];
    end
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (o_product !== 16'h0001 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_drain got prod=%h busy=%b want 0001 0", o_product, o_busy);
    end
  endtask

  task automatic test_reset_abort();
    int   dones;
    int   bc;
    logic gd;
    @(negedge clk);
    i_start = 1'b1;
    i_a     = 8'd3;
    i_b     = 8'd5;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_product !== 16'h0000 || o_sel !== 3'b000) begin
      n_errors++;
      $display("FAIL abort_outputs got busy=%b done=%b prod=%h sel=%b want 0 0 0000 000",
               o_busy, o_done, o_product, o_sel);
    end
    #14;
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_done || o_busy) dones++;
    end
    n_checks++;
    if (dones != 0 || o_product !== 16'h0000) begin
      n_errors++;
      $display("FAIL abort_quiet got activity=%0d prod=%h want 0 0000", dones, o_product);
    end
    run_op(8'd6, 8'hFD, bc, gd);
    n_checks++;
    if (gd !== 1'b1 || bc != 4 || o_product !== 16'hFFEE) begin
      n_errors++;
      $display("FAIL abort_restart got done=%b busy=%0d prod=%h want 1 4 ffee",
               gd, bc, o_product);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel_seq();
    test_corners();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_ctrl.md
# booth_r4_seq_ctrl

Sequential radix-4 Booth multiplier controller. It accepts one signed operand pair per start handshake and recodes the multiplier two bits per cycle into the {neg, one, two} select code used by the Booth partial-product mux. It forms the selected partial product (0, ±A, ±2A) and accumulates it shifted into a 2N-bit signed product. It sits above the partial-product selection datapath and sequences it over N/2 cycles, trading area for latency against the array multiplier.

## Interface
- N, default 8: operand width in bits; must be even and ≥ 4. Partial-product width is N+2; product width is 2N.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  N  signed multiplicand; captured on the accepting edge.
- b  input  N  signed multiplier; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse when the product has been updated.
- product  output  2N  signed result register; holds the last completed result.
- sel  output  3  current Booth select code {neg, one, two}; 000 outside RUN.

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- IDLE with start=1: capture a into A_r and {b, 1'b0} into B_r (appended 0 is b₋₁), clear acc and iter, go to RUN.
- RUN: iteration i uses triplet {B_r[2i+1], B_r[2i], B_r[2i-1]}.
- Recode table, triplet → sel:
  - 000 and 111 → 000 (0)
  - 001 and 010 → 010 (+A)
  - 011 → 001 (+2A)
  - 100 → 101 (−2A)
  - 101 and 110 → 110 (−A)
- sel codes 011, 100 and 111 are never produced.
- Partial product pp is N+2 bits, taken from the sign-extended A_r: 0, A, A<<1, −A, or −(A<<1).
- Each RUN edge: acc ← acc + (sign_extend(pp) << 2i), computed modulo 2^(2N); then iter ← iter+1.
- After iteration N/2−1: product ← final acc, done ← 1 for one cycle, go to IDLE.
- The result equals the exact signed a·b for every input pair, including −2^(N−1)·−2^(N−1).
- start while in RUN is ignored; there is no queueing.
- product changes only on completion. Its value is stable from done until the next completion.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and product returns to 0.

## Timing
- Reset values: busy=0, done=0, product=0, sel=000, state IDLE, acc=0, iter=0.
- Edge E0, accepting edge (IDLE, start=1): busy=1 from E0.
- Edges E1..E(N/2) each perform one iteration.
  - sel during cycle k (between E(k) and E(k+1)) shows the code for iteration k, for k = 0..N/2−1.
  - sel is combinational from state, iter and B_r.
- At E(N/2): product updates, done=1 and busy=0 for one cycle. Latency from start to done is N/2 cycles (4 for N=8).
- A start held high during the done cycle is accepted at that edge. Back-to-back throughput is one result per N/2+1 cycles.
- a and b may change freely after E0.

## Test plan
- Reset then a=3, b=5, start pulse: busy for 4 cycles, then done pulse with product=0x000F; busy=0 and done=0 during and after reset.
- a=1, b=0x5A: sel sequence 101, 110, 001, 010 in cycles 0..3; product=0x005A.
- Corner values, each completing with a single done pulse:
  - a=0x80, b=0x80 → product=0x4000
  - a=0x80, b=0x7F → product=0xC080
  - a=0xFF, b=0xFF → product=0x0001
  - a=0, b=0x7F → product=0x0000
- Start 7×9, re-pulse start with a=2, b=2 at cycle 2 of RUN: the second start is ignored; product=0x003F after exactly 4 cycles and no second done.
- Start held high continuously with alternating operand pairs: done every 5 cycles with the correct products; product stable between done pulses.
- Assert rst_n=0 at cycle 2 of RUN for 1.5 cycles, asynchronously to clk: busy, done and product drop to 0 immediately. No done follows. A new start after release completes normally.
